// File: rtl/rs_pkg.sv
// Shared reservation-station / CDB definitions: widths, tag encodings, result entry.
// Combinational definitions only; no latency.
// No flow control lives here.
package rs_pkg;

   localparam int NUM_SRC   = 8;
   localparam int DATA_W    = 32;
   localparam int TAG_W     = 4;
   localparam int CDB_DEPTH = 2;
   localparam int SRC_W     = $clog2(NUM_SRC);

   // Tag 0 means "no producer / value ready" and never matches on the bus.
   typedef enum logic [TAG_W-1:0] {
      TAG_NONE  = 4'd0,
      TAG_ADD1  = 4'd1,
      TAG_ADD2  = 4'd2,
      TAG_ADD3  = 4'd3,
      TAG_MULT1 = 4'd4,
      TAG_MULT2 = 4'd5,
      TAG_LOAD1 = 4'd6,
      TAG_LOAD2 = 4'd7,
      TAG_LOAD3 = 4'd8
   } rs_tag_e;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } cdb_ent_t;

   // CDB slot of a producer is its tag minus one.
   function automatic logic [SRC_W-1:0] tag_to_src(input logic [TAG_W-1:0] tag);
      logic [TAG_W-1:0] idx;
      idx = tag - TAG_W'(1);
      return idx[SRC_W-1:0];
   endfunction

   function automatic logic [TAG_W-1:0] src_to_tag(input logic [SRC_W-1:0] src);
      return TAG_W'(src) + TAG_W'(1);
   endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO, DEPTH entries of W bits, head always presented.
// Push visible at head one edge after the write; no bypass.
// full refuses push (even with a same-cycle pop); flush empties and drops any push.
module cdb_src_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 36
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit end: buffers per-producer results, round-robin grants one per cycle.
// Push-to-broadcast minimum 2 edges; registered valid/tag/data/src outputs.
// fu_ready[i] drops when source i's FIFO is full; the bus itself never stalls.
module cdb_arbiter #(
   parameter int NUM_SRC = rs_pkg::NUM_SRC,
   parameter int DATA_W  = rs_pkg::DATA_W,
   parameter int TAG_W   = rs_pkg::TAG_W,
   parameter int DEPTH   = rs_pkg::CDB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [NUM_SRC-1:0]         fu_valid,
   input  logic [NUM_SRC*TAG_W-1:0]   fu_tag,
   input  logic [NUM_SRC*DATA_W-1:0]  fu_data,
   output logic [NUM_SRC-1:0]         fu_ready,
   output logic                       cdb_valid,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [DATA_W-1:0]          cdb_data,
   output logic [$clog2(NUM_SRC)-1:0] cdb_src
);

   import rs_pkg::*;

   localparam int S_W   = $clog2(NUM_SRC);
   localparam int ENT_W = TAG_W + DATA_W;

   logic [NUM_SRC-1:0] fifo_full;
   logic [NUM_SRC-1:0] fifo_empty;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [ENT_W-1:0]   head [NUM_SRC];
   logic [S_W-1:0]     rr_ptr;
   logic [S_W-1:0]     cand;
   logic [S_W-1:0]     win_idx;
   logic               win_vld;

   assign fu_ready = ~fifo_full;
   assign push     = fu_valid & fu_ready;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      cdb_src_fifo #(
         .DEPTH (DEPTH),
         .W     (ENT_W)
      ) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .push     (push[g]),
         .push_dat ({fu_tag[g*TAG_W +: TAG_W], fu_data[g*DATA_W +: DATA_W]}),
         .pop      (pop[g]),
         .full     (fifo_full[g]),
         .empty    (fifo_empty[g]),
         .head     (head[g])
      );
   end

   // First non-empty source at or after rr_ptr, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = S_W'((int'(rr_ptr) + k) % NUM_SRC);
         if (!win_vld && !fifo_empty[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      pop = '0;
      if (win_vld && !flush) pop[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
         rr_ptr    <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         cdb_valid <= win_vld;
         if (win_vld) begin
            {cdb_tag, cdb_data} <= head[win_idx];
            cdb_src             <= win_idx;
            rr_ptr              <= (win_idx == S_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed stimulus for cdb_arbiter checked against a queue-based model.
module tb_cdb_arbiter;
   import rs_pkg::*;

   localparam int ENT_W = TAG_W + DATA_W;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       flush;
   logic [NUM_SRC-1:0]         fu_valid;
   logic [NUM_SRC*TAG_W-1:0]   fu_tag;
   logic [NUM_SRC*DATA_W-1:0]  fu_data;
   logic [NUM_SRC-1:0]         fu_ready;
   logic                       cdb_valid;
   logic [TAG_W-1:0]           cdb_tag;
   logic [DATA_W-1:0]          cdb_data;
   logic [SRC_W-1:0]           cdb_src;

   logic [TAG_W-1:0]  v_tag  [NUM_SRC];
   logic [DATA_W-1:0] v_data [NUM_SRC];

   // Reference model: one queue per source plus the expected bus registers.
   logic [ENT_W-1:0]  mq [NUM_SRC][$];
   int                rr;
   logic              e_valid;
   logic [TAG_W-1:0]  e_tag;
   logic [DATA_W-1:0] e_data;
   logic [SRC_W-1:0]  e_src;

   int n_chk  = 0;
   int n_pass = 0;
   int bp_sent;
   int density;

   cdb_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_tag    (fu_tag),
      .fu_data   (fu_data),
      .fu_ready  (fu_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   always_comb begin
      fu_tag  = '0;
      fu_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         fu_tag[i*TAG_W +: TAG_W]    = v_tag[i];
         fu_data[i*DATA_W +: DATA_W] = v_data[i];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic drive(input int i, input logic [DATA_W-1:0] d);
      fu_valid[i] = 1'b1;
      v_tag[i]    = src_to_tag(SRC_W'(i));
      v_data[i]   = d;
   endtask

   task automatic drive_idle(input int i);
      if (!fu_valid[i]) drive(i, $urandom);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
      rr      = 0;
      e_valid = 1'b0;
      e_tag   = '0;
      e_data  = '0;
      e_src   = '0;
   endtask

   // Called just after a rising edge; advances one clock and checks both sides of it.
   task automatic step(input logic do_flush);
      logic [NUM_SRC-1:0] rdy;
      logic [NUM_SRC-1:0] acc;
      logic [ENT_W-1:0]   ent;
      int                 w;
      int                 j;
      flush = do_flush;
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) rdy[i] = (mq[i].size() < CDB_DEPTH);
      check("fu_ready", 64'(fu_ready), 64'(rdy));
      acc = fu_valid & rdy;
      if (do_flush) begin
         for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
         rr      = 0;
         e_valid = 1'b0;
      end else begin
         w = -1;
         for (int k = 0; k < NUM_SRC; k++) begin
            j = (rr + k) % NUM_SRC;
            if (w < 0 && mq[j].size() > 0) w = j;
         end
         if (w >= 0) begin
            ent     = mq[w].pop_front();
            e_tag   = ent[ENT_W-1 -: TAG_W];
            e_data  = ent[DATA_W-1:0];
            e_src   = SRC_W'(w);
            e_valid = 1'b1;
            rr      = (w + 1) % NUM_SRC;
         end else begin
            e_valid = 1'b0;
         end
         for (int i = 0; i < NUM_SRC; i++)
            if (acc[i]) mq[i].push_back({v_tag[i], v_data[i]});
      end
      @(posedge clk);
      #1;
      check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
      check("cdb_tag",   64'(cdb_tag),   64'(e_tag));
      check("cdb_data",  64'(cdb_data),  64'(e_data));
      check("cdb_src",   64'(cdb_src),   64'(e_src));
      for (int i = 0; i < NUM_SRC; i++) if (acc[i]) fu_valid[i] = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      fu_valid = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         v_tag[i]  = '0;
         v_data[i] = '0;
      end
      model_reset();
      #1;
      check("rst_ready", 64'(fu_ready),  64'({NUM_SRC{1'b1}}));
      check("rst_valid", 64'(cdb_valid), 64'(0));
      check("rst_tag",   64'(cdb_tag),   64'(0));
      check("rst_data",  64'(cdb_data),  64'(0));
      check("rst_src",   64'(cdb_src),   64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single result from source 2
      drive(2, 32'h0000_00AA);
      repeat (5) step(1'b0);

      // Simultaneous pushes on sources 0, 4, 7
      drive(0, 32'h1111_0000);
      drive(4, 32'h4444_0000);
      drive(7, 32'h7777_0000);
      repeat (5) step(1'b0);

      // Fairness: every source continuously valid
      repeat (30) begin
         for (int i = 0; i < NUM_SRC; i++) drive_idle(i);
         step(1'b0);
      end
      repeat (20) step(1'b0);

      // Backpressure on source 1 while the others stay busy
      bp_sent = 0;
      repeat (40) begin
         for (int i = 0; i < NUM_SRC; i++) if (i != 1) drive_idle(i);
         if (!fu_valid[1] && bp_sent < 3) begin
            drive(1, 32'hB0B0_0000 + 32'(bp_sent));
            bp_sent++;
         end
         step(1'b0);
      end
      repeat (25) step(1'b0);

      // Flush with a same-cycle push on source 3
      repeat (2) begin
         for (int i = 0; i < 5; i++) drive_idle(i);
         step(1'b0);
      end
      fu_valid = '0;
      drive(3, 32'hDEAD_0003);
      step(1'b1);
      repeat (3) step(1'b0);
      drive(6, 32'h0000_0666);
      repeat (4) step(1'b0);

      // Reset asserted mid-stream
      repeat (10) begin
         for (int i = 0; i < NUM_SRC; i++) drive_idle(i);
         step(1'b0);
      end
      check("pre_rst_valid", 64'(cdb_valid), 64'(e_valid));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(cdb_valid), 64'(0));
      check("mid_rst_tag",   64'(cdb_tag),   64'(0));
      check("mid_rst_data",  64'(cdb_data),  64'(0));
      check("mid_rst_src",   64'(cdb_src),   64'(0));
      check("mid_rst_ready", 64'(fu_ready),  64'({NUM_SRC{1'b1}}));
      fu_valid = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (6) step(1'b0);

      // Random traffic with varying load and occasional flush
      density = 30;
      for (int c = 0; c < 2400; c++) begin
         if (c % 200 == 0) density = $urandom_range(95, 5);
         for (int i = 0; i < NUM_SRC; i++)
            if (!fu_valid[i] && $urandom_range(99) < density) drive(i, $urandom);
         step($urandom_range(99) == 0);
      end
      fu_valid = '0;
      repeat (20) step(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Transmit end of the common data bus (CDB). The reservation stations snoop this bus through their valid/cdb inputs.
- Collects completed results (tag + 32-bit value) from up to 8 producers: 3 ADD, 2 MULT, 3 LOAD.
- Buffers each producer's results in a small per-source FIFO, arbitrates round-robin, and broadcasts at most one result per cycle as a registered valid/tag/data triple.
- Sits between the functional units/load buffers and every RS and register-status consumer.

Parameters:
- NUM_SRC, 8, number of result producers; source index = CDB slot.
- DATA_W, 32, result value width.
- TAG_W, 4, RS tag width; tag 0 is reserved for "no producer / value ready".
- DEPTH, 2, entries per source FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash: discard all buffered and in-flight results.
- fu_valid  in  NUM_SRC  per-source result valid.
- fu_tag  in  NUM_SRC*TAG_W  per-source producer tag; slice i = [i*TAG_W +: TAG_W].
- fu_data  in  NUM_SRC*DATA_W  per-source result value; slice i = [i*DATA_W +: DATA_W].
- fu_ready  out  NUM_SRC  per-source "FIFO can accept".
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  tag being broadcast.
- cdb_data  out  DATA_W  value being broadcast.
- cdb_src  out  $clog2(NUM_SRC)  index of the winning source, for debug and coverage.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all FIFOs empty; fu_ready = all ones.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - round-robin pointer = 0.
- Accept:
  - Source i pushes on a rising edge when fu_valid[i] && fu_ready[i].
  - fu_ready[i] = (count[i] != DEPTH). It is a function of registered count only, with no combinational path from fu_valid or from the pop.
  - A full FIFO refuses a push even in a cycle where it is also popped.
- fu_valid with fu_ready low: the producer holds tag/data stable until accepted. This is a bench assertion; the block does not check it.
- Arbitration, each cycle:
  - Candidates = non-empty FIFOs.
  - Winner = first candidate at or after rr_ptr, wrapping modulo NUM_SRC.
  - The winner's head is popped. On the next edge cdb_valid=1 and cdb_tag/cdb_data/cdb_src are loaded with the head.
  - rr_ptr becomes (winner+1) mod NUM_SRC.
  - With no candidates: cdb_valid=0 next edge, tag/data/src hold their previous values, rr_ptr unchanged.
- Latency:
  - A result pushed on edge t is first eligible at edge t+1 (it must be in the FIFO before arbitration; no bypass).
  - Minimum push-to-broadcast is therefore 2 edges: visible on cdb_* in the cycle after edge t+1.
- Throughput: one broadcast per cycle sustained while any FIFO is non-empty.
- cdb_valid is a one-cycle pulse per result. Each accepted result is broadcast exactly once, in per-source FIFO order.
- Fairness: with all sources continuously non-empty, every source wins once in every NUM_SRC consecutive grants.
- Simultaneous push and pop on a non-full FIFO: both take effect and count is unchanged. Pushing into an empty FIFO does not make it eligible that same cycle.
- Tag 0:
  - fu_valid with tag 0 is illegal (bench assertion).
  - The block passes it through unchanged. Consumers treat tag 0 as "never matches".
- flush (synchronous, highest priority):
  - all counts cleared; any push in the same cycle is dropped.
  - cdb_valid=0 next edge; rr_ptr=0.
  - fu_ready is all ones in the cycle after the flush.
- Reset asserted mid-operation: immediate clear per the reset values. No partial broadcast survives.
- Pointer wrap: the FIFO read/write pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package rs_pkg:
  - TAG_W, DATA_W, NUM_SRC.
  - Tag encodings, 0 reserved: TAG_NONE=0, TAG_ADD1..3=1..3, TAG_MULT1..2=4..5, TAG_LOAD1..3=6..8.
  - Source index = tag-1 by convention.
  - The same package is reused by the RS and register-status blocks.
- One sub-module, cdb_src_fifo:
  - DEPTH x (TAG_W+DATA_W) synchronous FIFO with push, pop, flush, full, empty and head outputs.
  - Instantiated NUM_SRC times.
- The round-robin arbiter and output register stay in cdb_arbiter.

Test Plan:
- Single result: after reset, source 2 pushes tag=3, data=0x0000_00AA for one cycle. Expect exactly one cycle with cdb_valid=1, tag=3, data=0xAA, src=2, visible 2 edges after the push; no further valid.
- Simultaneous: sources 0, 4 and 7 push in the same cycle (tags 1, 5, 8). Expect broadcasts on consecutive cycles in order src 0, 4, 7; rr_ptr ends at 0.
- Fairness: all 8 sources continuously valid with distinct data. Over 16 consecutive broadcasts each source appears exactly twice, in order 0..7, 0..7.
- Backpressure: source 1 pushes 3 results while sources 0, 2..7 stay busy. Expect fu_ready[1]=0 after 2 accepts; the third is accepted once space frees; all 3 emerge in FIFO order.
- Flush: fill 5 FIFOs, assert flush for one cycle together with a new push on source 3. Expect no further cdb_valid, all fu_ready=1 next cycle, and the next push on source 6 broadcast first.
- Reset mid-stream: assert rst_n=0 while cdb_valid=1. Expect cdb_valid/tag/data/src=0 immediately (asynchronous), and no buffered result broadcast after release.
